// File: rtl/meta_tag_array.sv
// meta_tag_array: valid + tag + true-LRU metadata store for a set-associative cache.
//
// Lookup is registered, with a latency of one cycle. The array is read
// combinationally in the request cycle, and the rsp_* outputs update on the
// next rising edge. A fill writes the tag, sets valid and makes the way MRU.
// The inv_all pulse starts a sweep of exactly SETS cycles. Each sweep cycle
// clears one set and restores that set's ages to the way index.
//
// Ports:
//   clk, rst          rising-edge clock; asynchronous active-low reset
//   lk_valid/set/tag  lookup request
//   rsp_valid/hit     registered response valid / hit
//   rsp_way           one-hot hit way (zero on miss)
//   rsp_victim        one-hot replacement candidate (held while rsp_valid=0)
//   fill_valid/set/tag/way   tag write into a one-hot way
//   inv_all, busy     invalidate-all sweep start pulse / sweep in progress
//   parity_err        registered parity-error pulse
//
// Optional feature macro: META_TAG_PARITY_EN
//   Defined:   each entry stores an even-parity bit over {valid, tag}. A
//              mismatch in the indexed set suppresses the hit, pulses
//              parity_err and reports the faulty way as the victim.
//   Undefined: no parity storage, and parity_err is tied to 0.
module meta_tag_array #(
  parameter int SETS  = 64,
  parameter int WAYS  = 2,
  parameter int TAG_W = 6,
  localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1,
  localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lk_valid,
  input  logic [SET_W-1:0] lk_set,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             rsp_valid,
  output logic             rsp_hit,
  output logic [WAYS-1:0]  rsp_way,
  output logic [WAYS-1:0]  rsp_victim,
  input  logic             fill_valid,
  input  logic [SET_W-1:0] fill_set,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic [WAYS-1:0]  fill_way,
  input  logic             inv_all,
  output logic             busy,
  output logic             parity_err
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  // A fill target must name exactly one way.
  function automatic logic is_onehot(input logic [WAYS-1:0] x);
    return (x != '0) && ((x & (x - WAYS'(1))) == '0);
  endfunction

  // Isolate the lowest set bit (lowest-index priority).
  function automatic logic [WAYS-1:0] lowest_oh(input logic [WAYS-1:0] x);
    return x & (~x + WAYS'(1));
  endfunction

`ifdef META_TAG_PARITY_EN
  // Even parity: stored bit makes {valid, tag, par} have an even number of ones.
  function automatic logic even_par(input logic v, input logic [TAG_W-1:0] t);
    return ^{v, t};
  endfunction
`endif

  state_t           state_r;
  logic [SET_W-1:0] sweep_cnt_r;
  logic             busy_r;

  logic [WAYS-1:0]  valid_r [SETS];
  logic [TAG_W-1:0] tag_r   [SETS][WAYS];
  logic [AGE_W-1:0] age_r   [SETS][WAYS];
`ifdef META_TAG_PARITY_EN
  logic             par_r   [SETS][WAYS];
  logic             parity_err_r;
`endif

  logic             rsp_valid_r;
  logic             rsp_hit_r;
  logic [WAYS-1:0]  rsp_way_r;
  logic [WAYS-1:0]  rsp_victim_r;

  logic [WAYS-1:0]  hit_vec_s;
  logic [WAYS-1:0]  hit_oh_s;
  logic [WAYS-1:0]  inv_vec_s;
  logic [WAYS-1:0]  age_max_vec_s;
  logic [WAYS-1:0]  perr_vec_s;
  logic [WAYS-1:0]  victim_s;
  logic             perr_s;
  logic             hit_s;
  logic             lk_en_s;
  logic             fill_en_s;
  logic             lk_upd_s;
  logic             sweep_clr_s;
  logic [AGE_W-1:0] fill_old_s;
  logic [AGE_W-1:0] hit_old_s;
  logic [AGE_W-1:0] fill_age_nx_s [WAYS];
  logic [AGE_W-1:0] hit_age_nx_s  [WAYS];

  assign lk_en_s     = lk_valid & ~busy_r;
  assign fill_en_s   = fill_valid & ~busy_r & is_onehot(fill_way);
  // A fill to the same set takes precedence, so the lookup's LRU touch is dropped.
  assign lk_upd_s    = lk_en_s & hit_s & ~(fill_en_s & (fill_set == lk_set));
  assign sweep_clr_s = (state_r == ST_SWEEP);

  // Lookup read: tag compare, parity check and victim choice for lk_set.
  always_comb begin
    hit_vec_s     = '0;
    inv_vec_s     = '0;
    age_max_vec_s = '0;
    perr_vec_s    = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec_s[w]     = valid_r[lk_set][w] && (tag_r[lk_set][w] == lk_tag);
      inv_vec_s[w]     = ~valid_r[lk_set][w];
      age_max_vec_s[w] = (age_r[lk_set][w] == AGE_W'(WAYS - 1));
`ifdef META_TAG_PARITY_EN
      perr_vec_s[w]    = ^{valid_r[lk_set][w], tag_r[lk_set][w], par_r[lk_set][w]};
`endif
    end
    perr_s   = |perr_vec_s;
    hit_oh_s = perr_s ? '0 : lowest_oh(hit_vec_s);
    hit_s    = |hit_oh_s;
    if (perr_s) begin
      victim_s = lowest_oh(perr_vec_s);
    end else if (WAYS == 1) begin
      victim_s = WAYS'(1);
    end else if (|inv_vec_s) begin
      victim_s = lowest_oh(inv_vec_s);
    end else begin
      victim_s = age_max_vec_s;
    end
  end

  // Next LRU ages for the fill set and the hit set. The accessed way becomes 0,
  // and every way younger than it ages by one.
  always_comb begin
    fill_old_s = '0;
    hit_old_s  = '0;
    for (int w = 0; w < WAYS; w++) begin
      fill_old_s |= fill_way[w] ? age_r[fill_set][w] : '0;
      hit_old_s  |= hit_oh_s[w] ? age_r[lk_set][w]   : '0;
    end
    for (int w = 0; w < WAYS; w++) begin
      fill_age_nx_s[w] = fill_way[w] ? '0 :
                         (age_r[fill_set][w] < fill_old_s) ? age_r[fill_set][w] + AGE_W'(1) :
                         age_r[fill_set][w];
      hit_age_nx_s[w]  = hit_oh_s[w] ? '0 :
                         (age_r[lk_set][w] < hit_old_s) ? age_r[lk_set][w] + AGE_W'(1) :
                         age_r[lk_set][w];
    end
  end

  // Invalidate-all sequencer: IDLE -> SWEEP for exactly SETS cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      sweep_cnt_r <= '0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (inv_all) begin
            state_r     <= ST_SWEEP;
            sweep_cnt_r <= '0;
            busy_r      <= 1'b1;
          end else begin
            busy_r      <= 1'b0;
          end
        end
        ST_SWEEP: begin
          if (sweep_cnt_r == SET_W'(SETS - 1)) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            sweep_cnt_r <= sweep_cnt_r + SET_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Metadata storage: sweep clear, fill write, and the lookup-hit LRU touch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_r[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tag_r[s][w] <= '0;
          age_r[s][w] <= AGE_W'(w);
`ifdef META_TAG_PARITY_EN
          par_r[s][w] <= 1'b0;
`endif
        end
      end
    end else begin
      for (int s = 0; s < SETS; s++) begin
        if (sweep_clr_s && (sweep_cnt_r == SET_W'(s))) begin
          valid_r[s] <= '0;
          for (int w = 0; w < WAYS; w++) begin
            age_r[s][w] <= AGE_W'(w);
`ifdef META_TAG_PARITY_EN
            par_r[s][w] <= even_par(1'b0, tag_r[s][w]);
`endif
          end
        end else if (fill_en_s && (fill_set == SET_W'(s))) begin
          for (int w = 0; w < WAYS; w++) begin
            age_r[s][w] <= fill_age_nx_s[w];
            if (fill_way[w]) begin
              valid_r[s][w] <= 1'b1;
              tag_r[s][w]   <= fill_tag;
`ifdef META_TAG_PARITY_EN
              par_r[s][w]   <= even_par(1'b1, fill_tag);
`endif
            end
          end
        end else if (lk_upd_s && (lk_set == SET_W'(s))) begin
          for (int w = 0; w < WAYS; w++) begin
            age_r[s][w] <= hit_age_nx_s[w];
          end
        end
      end
    end
  end

  // Registered lookup response; the victim holds while no response is issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_r  <= 1'b0;
      rsp_hit_r    <= 1'b0;
      rsp_way_r    <= '0;
      rsp_victim_r <= '0;
    end else begin
      rsp_valid_r <= lk_en_s;
      if (lk_en_s) begin
        rsp_hit_r    <= hit_s;
        rsp_way_r    <= hit_oh_s;
        rsp_victim_r <= victim_s;
      end else begin
        rsp_hit_r    <= 1'b0;
        rsp_way_r    <= '0;
      end
    end
  end

`ifdef META_TAG_PARITY_EN
  // Parity-error pulse, aligned with the lookup response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_err_r <= 1'b0;
    end else begin
      parity_err_r <= lk_en_s & perr_s;
    end
  end
  assign parity_err = parity_err_r;
`else
  assign parity_err = 1'b0;
`endif

  assign rsp_valid  = rsp_valid_r;
  assign rsp_hit    = rsp_hit_r;
  assign rsp_way    = rsp_way_r;
  assign rsp_victim = rsp_victim_r;
  assign busy       = busy_r;

endmodule
